// File: rtl/par2ser_gearbox_pkg.sv
// Shared definitions for the parallel-to-serial gearbox.
//   ser_state_e : gearbox mode (IDLE=0, RUN=1, TRAIN=2), also exported on o_state
//   CTL0..CTL3  : TMDS control tokens; CTL0 is the default underflow fill word
//   beats()     : serclk beats needed to emit one parallel word
//   cfg_ok()    : legal width combination (whole number of beats, at least two)
package par2ser_gearbox_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StTrain = 2'd2
    } ser_state_e;

    localparam logic [9:0] CTL0 = 10'b1101010100;
    localparam logic [9:0] CTL1 = 10'b0010101011;
    localparam logic [9:0] CTL2 = 10'b0101010100;
    localparam logic [9:0] CTL3 = 10'b1010101011;

    function automatic int unsigned beats(input int unsigned data_w, input int unsigned out_w);
        return (out_w == 0) ? 0 : data_w / out_w;
    endfunction

    function automatic bit cfg_ok(input int unsigned data_w, input int unsigned out_w);
        return (out_w != 0) && (data_w % out_w == 0) && (data_w / out_w >= 2);
    endfunction

endpackage

// File: rtl/par2ser_gearbox_lane.sv
// One gearbox lane: a DATA_W shift register that loads a whole word at a word
// boundary and otherwise shifts OUT_W bits per serclk toward the output slice.
//   i_serclk    : gearbox clock
//   i_rst_n     : async active-low reset, register fills with INIT_OQ
//   i_load      : load i_load_word this edge instead of shifting
//   i_load_word : next word for this lane
//   o_dout      : current beat, bit 0 is the earlier bit on the line
module par2ser_gearbox_lane #(
    parameter int unsigned DATA_W    = 10,
    parameter int unsigned OUT_W     = 2,
    parameter bit          LSB_FIRST = 1'b1,
    parameter logic        INIT_OQ   = 1'b0
) (
    input  logic              i_serclk,
    input  logic              i_rst_n,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_load_word,
    output logic [OUT_W-1:0]  o_dout
);

    logic [DATA_W-1:0] r_sh;
    logic [DATA_W-1:0] w_sh_d;

    always_comb begin
        w_sh_d = r_sh;
        if (i_load) begin
            w_sh_d = i_load_word;
        end else if (LSB_FIRST) begin
            w_sh_d = {{OUT_W{INIT_OQ}}, r_sh[DATA_W-1:OUT_W]};
        end else begin
            w_sh_d = {r_sh[DATA_W-OUT_W-1:0], {OUT_W{INIT_OQ}}};
        end
    end

    always_ff @(posedge i_serclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sh <= {DATA_W{INIT_OQ}};
        end else begin
            r_sh <= w_sh_d;
        end
    end

    // MSB-first lanes read the top slice reversed so o_dout[0] is still the earlier bit.
    always_comb begin
        o_dout = '0;
        for (int i = 0; i < int'(OUT_W); i++) begin
            if (LSB_FIRST) begin
                o_dout[i] = r_sh[i];
            end else begin
                o_dout[i] = r_sh[int'(DATA_W) - 1 - i];
            end
        end
    end

endmodule

// File: rtl/par2ser_gearbox.sv
// Multi-lane parallel-to-serial gearbox with a one-word hold buffer, underflow
// fill, a training-pattern mode and an enable/idle mode.
//   i_serclk, i_rst_n     : gearbox clock, async active-low reset
//   i_enable              : 1 stream, 0 finish current word then go IDLE
//   i_train_req           : send i_train_pattern on every lane instead of data
//   i_s_valid/o_s_ready   : word handshake, i_s_data lane k at [k*DATA_W +: DATA_W]
//   o_dout                : lane k at [k*OUT_W +: OUT_W]
//   o_word_start          : dout carries beat 0 of a word (never in IDLE)
//   o_underflow_cnt       : saturating count of IDLE_WORD insertions
//   o_state               : IDLE=0, RUN=1, TRAIN=2
module par2ser_gearbox
    import par2ser_gearbox_pkg::*;
#(
    parameter int unsigned       CHANNELS  = 4,
    parameter int unsigned       DATA_W    = 10,
    parameter int unsigned       OUT_W     = 2,
    parameter bit                LSB_FIRST = 1'b1,
    parameter logic              INIT_OQ   = 1'b0,
    parameter logic [DATA_W-1:0] IDLE_WORD = CTL0
) (
    input  logic                         i_serclk,
    input  logic                         i_rst_n,
    input  logic                         i_enable,
    input  logic                         i_train_req,
    input  logic [DATA_W-1:0]            i_train_pattern,
    input  logic                         i_s_valid,
    output logic                         o_s_ready,
    input  logic [CHANNELS*DATA_W-1:0]   i_s_data,
    output logic [CHANNELS*OUT_W-1:0]    o_dout,
    output logic                         o_word_start,
    output logic [15:0]                  o_underflow_cnt,
    output logic [1:0]                   o_state
);

    localparam int unsigned       BEATS   = beats(DATA_W, OUT_W);
    localparam int unsigned       CNT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(BEATS - 1);

    if (!cfg_ok(DATA_W, OUT_W)) begin : g_cfg_check
        $error("par2ser_gearbox: DATA_W must be a multiple of OUT_W giving at least two beats");
    end

    ser_state_e                  r_state;
    ser_state_e                  w_state_d;
    logic [CNT_W-1:0]            r_cnt;
    logic [CNT_W-1:0]            w_cnt_d;
    logic                        r_hold_vld;
    logic                        w_hold_vld_d;
    logic [CHANNELS*DATA_W-1:0]  r_hold;
    logic                        r_word_start;
    logic                        w_word_start_d;
    logic [15:0]                 r_underflow_cnt;
    logic                        w_boundary;
    logic                        w_consume;
    logic                        w_uf_inc;
    logic                        w_accept;

    // State register.
    always_ff @(posedge i_serclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Next state: mode changes only land on a word boundary so words never get cut.
    always_comb begin
        w_state_d = r_state;
        if (w_boundary) begin
            if (!i_enable) begin
                w_state_d = StIdle;
            end else if (i_train_req) begin
                w_state_d = StTrain;
            end else begin
                w_state_d = StRun;
            end
        end
    end

    // FSM-derived controls. IDLE is a boundary every cycle so a restart needs no wait.
    always_comb begin
        w_boundary = (r_cnt == CNT_MAX) || (r_state == StIdle);
        w_consume  = w_boundary && (w_state_d == StRun) && r_hold_vld;
        w_uf_inc   = w_boundary && (w_state_d == StRun) && !r_hold_vld;
        o_s_ready  = !r_hold_vld || w_consume;
        w_accept   = i_s_valid && o_s_ready;
        o_state    = r_state;
    end

    always_comb begin
        w_cnt_d = r_cnt + 1'b1;
        if ((w_state_d == StIdle) || (r_state == StIdle) || (r_cnt == CNT_MAX)) begin
            w_cnt_d = '0;
        end
        // A new word entering the hold in the consume cycle keeps the buffer full.
        w_hold_vld_d = r_hold_vld;
        if (w_accept) begin
            w_hold_vld_d = 1'b1;
        end else if (w_consume) begin
            w_hold_vld_d = 1'b0;
        end
        w_word_start_d = (w_cnt_d == '0) && (w_state_d != StIdle);
    end

    always_ff @(posedge i_serclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt           <= '0;
            r_hold_vld      <= 1'b0;
            r_hold          <= '0;
            r_word_start    <= 1'b0;
            r_underflow_cnt <= '0;
        end else begin
            r_cnt        <= w_cnt_d;
            r_hold_vld   <= w_hold_vld_d;
            r_word_start <= w_word_start_d;
            if (w_accept) begin
                r_hold <= i_s_data;
            end
            if (w_uf_inc && (r_underflow_cnt != 16'hFFFF)) begin
                r_underflow_cnt <= r_underflow_cnt + 16'd1;
            end
        end
    end

    assign o_word_start    = r_word_start;
    assign o_underflow_cnt = r_underflow_cnt;

    for (genvar k = 0; k < int'(CHANNELS); k++) begin : g_lane
        logic [DATA_W-1:0] w_load_word;

        always_comb begin
            w_load_word = {DATA_W{INIT_OQ}};
            unique case (w_state_d)
                StIdle:  w_load_word = {DATA_W{INIT_OQ}};
                StTrain: w_load_word = i_train_pattern;
                default: w_load_word = r_hold_vld ? r_hold[k*DATA_W +: DATA_W] : IDLE_WORD;
            endcase
        end

        par2ser_gearbox_lane #(
            .DATA_W    (DATA_W),
            .OUT_W     (OUT_W),
            .LSB_FIRST (LSB_FIRST),
            .INIT_OQ   (INIT_OQ)
        ) u_lane (
            .i_serclk    (i_serclk),
            .i_rst_n     (i_rst_n),
            .i_load      (w_boundary),
            .i_load_word (w_load_word),
            .o_dout      (o_dout[k*OUT_W +: OUT_W])
        );
    end

endmodule

// File: tb/tb_par2ser_gearbox.sv
// Directed bench: 4-lane LSB-first OUT_W=2 gearbox plus a 1-lane MSB-first OUT_W=5 instance.
module tb_par2ser_gearbox;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        train_req = 1'b0;
    logic [9:0]  train_pattern = 10'h3E0;
    logic        s_valid = 1'b0;
    logic [39:0] s_data = '0;
    logic        s_ready;
    logic [7:0]  dout;
    logic        word_start;
    logic [15:0] uf;
    logic [1:0]  state;

    logic        b_enable = 1'b0;
    logic        b_valid = 1'b0;
    logic [9:0]  b_data = '0;
    logic        b_ready;
    logic [4:0]  b_dout;
    logic        b_ws;
    logic [15:0] b_uf;
    logic [1:0]  b_state;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    par2ser_gearbox #(
        .CHANNELS(4), .DATA_W(10), .OUT_W(2), .LSB_FIRST(1'b1), .INIT_OQ(1'b0),
        .IDLE_WORD(10'b1101010100)
    ) dut (
        .i_serclk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_train_req(train_req),
        .i_train_pattern(train_pattern), .i_s_valid(s_valid), .o_s_ready(s_ready),
        .i_s_data(s_data), .o_dout(dout), .o_word_start(word_start),
        .o_underflow_cnt(uf), .o_state(state)
    );

    par2ser_gearbox #(
        .CHANNELS(1), .DATA_W(10), .OUT_W(5), .LSB_FIRST(1'b0), .INIT_OQ(1'b0),
        .IDLE_WORD(10'b1101010100)
    ) dut_b (
        .i_serclk(clk), .i_rst_n(rst_n), .i_enable(b_enable), .i_train_req(1'b0),
        .i_train_pattern(10'h3E0), .i_s_valid(b_valid), .o_s_ready(b_ready),
        .i_s_data(b_data), .o_dout(b_dout), .o_word_start(b_ws),
        .o_underflow_cnt(b_uf), .o_state(b_state)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    // Check one beat (dout, word_start, state) then advance one clock.
    task automatic chk_beat(input string tag, input logic [7:0] d, input logic ws,
                            input logic [1:0] st);
        chk({tag, " dout"}, dout, d);
        chk({tag, " word_start"}, word_start, ws);
        chk({tag, " state"}, state, st);
        tick();
    endtask

    // beats_v[7:0] is beat 0.
    task automatic chk_word(input string tag, input logic [39:0] beats_v, input logic [1:0] st);
        for (int b = 0; b < 5; b++) begin
            chk_beat(tag, beats_v[b*8 +: 8], (b == 0), st);
        end
    endtask

    function automatic logic [39:0] wv(input int i);
        logic [39:0] w;
        for (int k = 0; k < 4; k++) begin
            w[k*10 +: 10] = 10'((i * 97 + k * 13 + 5) % 1024);
        end
        return w;
    endfunction

    function automatic logic [7:0] beat0(input logic [39:0] w);
        return {w[31:30], w[21:20], w[11:10], w[1:0]};
    endfunction

    // Five-beat dout images, beat 0 in the low byte.
    localparam logic [39:0] W2A5 = {8'hAA, 8'hAA, 8'hAA, 8'h55, 8'h55};
    localparam logic [39:0] WIDL = {8'hFF, 8'h55, 8'h55, 8'h55, 8'h00};
    localparam logic [39:0] WTRN = {8'hFF, 8'hFF, 8'hAA, 8'h00, 8'h00};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        int ws_seen;
        int cyc;
        int last_acc;
        logic acc;

        #1;
        chk("rst dout", dout, 8'h00);
        chk("rst word_start", word_start, 1'b0);
        chk("rst underflow", uf, 16'd0);
        chk("rst state", state, 2'd0);
        chk("rst b dout", b_dout, 5'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Word parked in the hold while idle, then enable starts it at beat 0.
        s_data = {4{10'h2A5}};
        s_valid = 1'b1;
        #1 chk("t1 ready empty", s_ready, 1'b1);
        tick();
        s_valid = 1'b0;
        #1 chk("t1 ready full idle", s_ready, 1'b0);
        chk("t1 idle dout", dout, 8'h00);
        chk("t1 idle state", state, 2'd0);
        enable = 1'b1;
        #1 chk("t1 ready consume", s_ready, 1'b1);
        tick();
        chk("t1 no underflow", uf, 16'd0);
        chk_word("t1 word", W2A5, 2'd1);

        // Hold empty: IDLE_WORD fills, one count per word.
        chk("t3 uf first", uf, 16'd1);
        chk_word("t3 idle word", WIDL, 2'd1);
        chk("t3 uf second", uf, 16'd2);

        // Continuous stream of 20 words.
        idx = 0;
        ws_seen = 0;
        cyc = 0;
        last_acc = 0;
        s_data = wv(0);
        s_valid = 1'b1;
        while (ws_seen < 20 && cyc < 200) begin
            #1 acc = s_valid && s_ready;
            if (acc) begin
                if (idx == 1) chk("t2 first gap", cyc - last_acc, 4);
                if (idx >= 2) chk("t2 accept gap", cyc - last_acc, 5);
                last_acc = cyc;
                idx++;
            end
            tick();
            cyc++;
            if (acc) begin
                if (idx < 20) s_data = wv(idx);
                else s_valid = 1'b0;
            end
            if (word_start) begin
                chk("t2 beat0", dout, beat0(wv(ws_seen)));
                ws_seen++;
            end
        end
        chk("t2 words seen", ws_seen, 20);
        chk("t2 accepts", idx, 20);
        chk("t2 no underflow", uf, 16'd2);

        tick(5);
        chk("t4 uf before", uf, 16'd3);
        chk("t4 idle beat0", dout, 8'h00);

        // Training requested at beat 2 with a word waiting in the hold.
        s_data = {4{10'h0F3}};
        s_valid = 1'b1;
        #1 chk("t4 ready", s_ready, 1'b1);
        tick();
        s_valid = 1'b0;
        chk_beat("t4 c1", 8'h55, 1'b0, 2'd1);
        train_req = 1'b1;
        chk_beat("t4 c2", 8'h55, 1'b0, 2'd1);
        chk_beat("t4 c3", 8'h55, 1'b0, 2'd1);
        #1 chk("t4 hold kept", s_ready, 1'b0);
        chk_beat("t4 c4", 8'hFF, 1'b0, 2'd1);
        chk_word("t4 train1", WTRN, 2'd2);
        chk_beat("t4 tr2 b0", 8'h00, 1'b1, 2'd2);
        chk_beat("t4 tr2 b1", 8'h00, 1'b0, 2'd2);
        train_req = 1'b0;
        chk_beat("t4 tr2 b2", 8'hAA, 1'b0, 2'd2);
        chk_beat("t4 tr2 b3", 8'hFF, 1'b0, 2'd2);
        #1 chk("t4 consume after train", s_ready, 1'b1);
        chk_beat("t4 tr2 b4", 8'hFF, 1'b0, 2'd2);
        chk("t4 no underflow in train", uf, 16'd3);

        // Held word, with enable dropped at beat 1.
        chk_beat("t5 h b0", 8'hFF, 1'b1, 2'd1);
        enable = 1'b0;
        chk_beat("t5 h b1", 8'h00, 1'b0, 2'd1);
        chk_beat("t5 h b2", 8'hFF, 1'b0, 2'd1);
        chk_beat("t5 h b3", 8'hFF, 1'b0, 2'd1);
        chk_beat("t5 h b4", 8'h00, 1'b0, 2'd1);
        chk_beat("t5 idle a", 8'h00, 1'b0, 2'd0);
        chk_beat("t5 idle b", 8'h00, 1'b0, 2'd0);
        chk("t5 idle uf", uf, 16'd3);
        enable = 1'b1;
        tick();
        chk("t5 restart uf", uf, 16'd4);
        chk_beat("t5 restart", 8'h00, 1'b1, 2'd1);

        // Saturation from a preset near the top.
        force dut.r_underflow_cnt = 16'hFFFE;
        #1 release dut.r_underflow_cnt;
        tick(4);
        chk("t3 sat reach", uf, 16'hFFFF);
        tick(5);
        chk("t3 sat hold", uf, 16'hFFFF);

        // Asynchronous reset mid-word.
        tick(3);
        rst_n = 1'b0;
        #1;
        chk("t6 rst dout", dout, 8'h00);
        chk("t6 rst uf", uf, 16'd0);
        chk("t6 rst state", state, 2'd0);
        chk("t6 rst ws", word_start, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("t6 ready after rst", s_ready, 1'b1);

        // MSB-first, five bits per beat.
        b_data = 10'h2A5;
        b_valid = 1'b1;
        tick();
        b_valid = 1'b0;
        b_enable = 1'b1;
        tick();
        chk("b beat0", b_dout, 5'h15);
        chk("b ws0", b_ws, 1'b1);
        chk("b state", b_state, 2'd1);
        tick();
        chk("b beat1", b_dout, 5'h14);
        chk("b ws1", b_ws, 1'b0);
        tick();
        chk("b idle word beat0", b_dout, 5'h0B);
        chk("b uf", b_uf, 16'd1);
        chk("b ready", b_ready, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
